// File: rtl/bcd_to_seven_segment.sv
// Registered BCD-to-seven-segment decoder for a single display digit.
// Lamp test overrides blanking, which overrides the digit decode; output polarity is a parameter.
module bcd_to_seven_segment #(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] bcd,
    input  logic       blank,
    input  logic       lamp_test,
    output logic [6:0] segment,
    output logic       invalid
);

    logic [6:0] lit_d;
    logic [6:0] lit_q;
    logic       invalid_d;
    logic       invalid_q;

    // lit bit order is {a,b,c,d,e,f,g}
    always_comb begin
        lit_d     = 7'b0000000;
        invalid_d = 1'b0;
        if (lamp_test) begin
            lit_d = 7'b1111111;
        end else if (blank) begin
            lit_d = 7'b0000000;
        end else begin
            unique case (bcd)
                4'd0:    lit_d = 7'b1111110;
                4'd1:    lit_d = 7'b0110000;
                4'd2:    lit_d = 7'b1101101;
                4'd3:    lit_d = 7'b1111001;
                4'd4:    lit_d = 7'b0110011;
                4'd5:    lit_d = 7'b1011011;
                4'd6:    lit_d = 7'b1011111;
                4'd7:    lit_d = 7'b1110000;
                4'd8:    lit_d = 7'b1111111;
                4'd9:    lit_d = 7'b1111011;
                default: begin
                    lit_d     = 7'b0000000;
                    invalid_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lit_q     <= 7'b0000000;
            invalid_q <= 1'b0;
        end else begin
            lit_q     <= lit_d;
            invalid_q <= invalid_d;
        end
    end

    // Polarity is applied after the register so a reset display is dark for either pad type.
    assign segment = ACTIVE_LOW ? ~lit_q : lit_q;
    assign invalid = invalid_q;

endmodule

// File: tb/tb_bcd_to_seven_segment.sv
// Self-checking bench: one common-cathode and one common-anode instance share the stimulus
// and are compared against a table-driven model of the digit display.
module tb_bcd_to_seven_segment;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] bcd = 4'd0;
    logic       blank = 1'b0;
    logic       lamp_test = 1'b0;
    logic [6:0] seg_h;
    logic [6:0] seg_l;
    logic       inv_h;
    logic       inv_l;

    int n_checks = 0;
    int n_fail = 0;

    logic [6:0] digit_tab [10];
    logic [6:0] e_lit;
    logic       e_inv;

    always #5 clk = ~clk;

    bcd_to_seven_segment #(.ACTIVE_LOW(1'b0)) dut_h (
        .clk(clk), .rst(rst), .bcd(bcd), .blank(blank), .lamp_test(lamp_test),
        .segment(seg_h), .invalid(inv_h)
    );

    bcd_to_seven_segment #(.ACTIVE_LOW(1'b1)) dut_l (
        .clk(clk), .rst(rst), .bcd(bcd), .blank(blank), .lamp_test(lamp_test),
        .segment(seg_l), .invalid(inv_l)
    );

    // Expected lit pattern and invalid flag for the inputs present at an edge.
    task automatic model(input logic r, input logic [3:0] b, input logic lt, input logic bl);
        e_inv = 1'b0;
        if (r)                   e_lit = 7'b0000000;
        else if (lt)             e_lit = 7'b1111111;
        else if (bl)             e_lit = 7'b0000000;
        else if (int'(b) <= 9)   e_lit = digit_tab[b];
        else begin
            e_lit = 7'b0000000;
            e_inv = 1'b1;
        end
    endtask

    // Drive inputs, compute the expectation, then step one edge and sample 1 time unit later.
    task automatic apply(input logic r, input logic [3:0] b, input logic lt, input logic bl);
        rst = r; bcd = b; lamp_test = lt; blank = bl;
        model(r, b, lt, bl);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            apply(1'b1, 4'd8, 1'b1, 1'b0);
            n_checks++;
            if (seg_h !== 7'b0000000) begin
                n_fail++; $display("FAIL reset seg_h got %b exp 0000000", seg_h);
            end
            n_checks++;
            if (seg_l !== 7'b1111111) begin
                n_fail++; $display("FAIL reset seg_l got %b exp 1111111", seg_l);
            end
            n_checks++;
            if (inv_h !== 1'b0 || inv_l !== 1'b0) begin
                n_fail++; $display("FAIL reset invalid got %b/%b exp 0", inv_h, inv_l);
            end
        end
    endtask

    task automatic test_sweep_valid();
        for (int d = 0; d <= 9; d++) begin
            apply(1'b0, 4'(d), 1'b0, 1'b0);
            n_checks++;
            if (seg_h !== e_lit) begin
                n_fail++; $display("FAIL sweep_valid bcd=%0d seg_h got %b exp %b", d, seg_h, e_lit);
            end
            n_checks++;
            if (inv_h !== 1'b0) begin
                n_fail++; $display("FAIL sweep_valid bcd=%0d invalid got %b exp 0", d, inv_h);
            end
        end
    endtask

    task automatic test_sweep_invalid();
        for (int d = 10; d <= 15; d++) begin
            apply(1'b0, 4'(d), 1'b0, 1'b0);
            n_checks++;
            if (seg_h !== 7'b0000000 || seg_l !== 7'b1111111) begin
                n_fail++; $display("FAIL sweep_invalid bcd=%0d seg got %b/%b exp 0000000/1111111", d, seg_h, seg_l);
            end
            n_checks++;
            if (inv_h !== 1'b1 || inv_l !== 1'b1) begin
                n_fail++; $display("FAIL sweep_invalid bcd=%0d invalid got %b/%b exp 1", d, inv_h, inv_l);
            end
        end
        apply(1'b0, 4'd3, 1'b0, 1'b0);
        n_checks++;
        if (seg_h !== 7'b1111001 || inv_h !== 1'b0) begin
            n_fail++; $display("FAIL invalid_recover seg/inv got %b/%b exp 1111001/0", seg_h, inv_h);
        end
    endtask

    task automatic test_overrides();
        logic [3:0] ob  [4] = '{4'd1, 4'd1, 4'd1, 4'd12};
        logic       olt [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic       obl [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [6:0] oexp [4] = '{7'b1111111, 7'b0000000, 7'b1111111, 7'b1111111};
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, ob[i], olt[i], obl[i]);
            n_checks++;
            if (seg_h !== oexp[i]) begin
                n_fail++; $display("FAIL override[%0d] seg_h got %b exp %b", i, seg_h, oexp[i]);
            end
            n_checks++;
            if (inv_h !== 1'b0) begin
                n_fail++; $display("FAIL override[%0d] invalid got %b exp 0", i, inv_h);
            end
        end
    endtask

    task automatic test_polarity();
        apply(1'b0, 4'd0, 1'b0, 1'b0);
        n_checks++;
        if (seg_l !== 7'b0000001) begin
            n_fail++; $display("FAIL polarity bcd=0 seg_l got %b exp 0000001", seg_l);
        end
        apply(1'b0, 4'd7, 1'b0, 1'b0);
        n_checks++;
        if (seg_l !== 7'b0001111) begin
            n_fail++; $display("FAIL polarity bcd=7 seg_l got %b exp 0001111", seg_l);
        end
    endtask

    task automatic test_reset_midstream();
        for (int d = 0; d < 5; d++) apply(1'b0, 4'(d), 1'b0, 1'b0);
        apply(1'b1, 4'd5, 1'b0, 1'b0);
        n_checks++;
        if (seg_h !== 7'b0000000 || seg_l !== 7'b1111111) begin
            n_fail++; $display("FAIL reset_mid seg got %b/%b exp 0000000/1111111", seg_h, seg_l);
        end
        apply(1'b0, 4'd6, 1'b0, 1'b0);
        n_checks++;
        if (seg_h !== 7'b1011111) begin
            n_fail++; $display("FAIL reset_mid_release seg_h got %b exp 1011111", seg_h);
        end
    endtask

    task automatic test_back_to_back_random();
        for (int i = 0; i < 300; i++) begin
            apply(($urandom_range(0, 31) == 0), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
            n_checks++;
            if (seg_h !== e_lit || seg_l !== ~e_lit) begin
                n_fail++;
                $display("FAIL random[%0d] rst=%b bcd=%0d lt=%b bl=%b seg got %b/%b exp %b/%b",
                         i, rst, bcd, lamp_test, blank, seg_h, seg_l, e_lit, ~e_lit);
            end
            n_checks++;
            if (inv_h !== e_inv || inv_l !== e_inv) begin
                n_fail++; $display("FAIL random[%0d] invalid got %b/%b exp %b", i, inv_h, inv_l, e_inv);
            end
        end
    endtask

    initial begin
        digit_tab[0] = 7'b1111110; digit_tab[1] = 7'b0110000;
        digit_tab[2] = 7'b1101101; digit_tab[3] = 7'b1111001;
        digit_tab[4] = 7'b0110011; digit_tab[5] = 7'b1011011;
        digit_tab[6] = 7'b1011111; digit_tab[7] = 7'b1110000;
        digit_tab[8] = 7'b1111111; digit_tab[9] = 7'b1111011;
        test_reset();
        test_sweep_valid();
        test_sweep_invalid();
        test_overrides();
        test_polarity();
        test_reset_midstream();
        test_back_to_back_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
